fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width.
REQ-002 SHALL have parameter BURST_LEN, default 8, meaning beats per burst (legal range 1..256).
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_rdata  input  DW  FIFO read data, valid one cycle after an accepted read.
REQ-007 SHALL have port fifo_r_en  output  1  FIFO read request, combinational.
REQ-008 SHALL have port m_valid  output  1  downstream word valid.
REQ-009 SHALL have port m_ready  input  1  downstream accept.
REQ-010 SHALL have port m_data  output  DW  downstream word.
REQ-011 SHALL have port m_last  output  1  final beat of a burst.
REQ-012 SHALL have port flush  input  1  single-cycle discard request.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL assert fifo_r_en only when fifo_empty=0, flush=0, state!=FLUSH, and (occupancy+inflight-pop)<2; pop = m_valid&m_ready.
REQ-015 SHALL set the inflight flag on each fifo_r_en cycle and write fifo_rdata into a 2-entry output buffer on the following cycle.
REQ-016 SHALL drive m_valid=1 whenever buffer occupancy>0; m_data is the oldest entry.
REQ-017 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-018 SHALL give a latency of 2 cycles from the first fifo_r_en cycle to m_valid=1.
REQ-019 SHALL sustain one word per cycle when m_ready=1 and fifo_empty=0.
REQ-020 SHALL keep an 8-bit beat counter; increment on pop; m_last=1 when counter==BURST_LEN-1; counter wraps to 0 on that pop.
REQ-021 SHALL implement FSM IDLE/RUN/FLUSH: IDLE->RUN when fifo_empty=0; RUN->IDLE when occupancy=0, inflight=0 and fifo_empty=1; any->FLUSH on flush=1; FLUSH->IDLE after exactly one cycle.
REQ-022 SHALL, on flush, clear buffer occupancy, beat counter and inflight, and discard any fifo_rdata returning in the FLUSH cycle.
REQ-023 SHALL let flush take priority over a simultaneous pop; the popped word counts as delivered, the counter still clears.
REQ-024 SHALL handle a simultaneous arrival and pop at occupancy 2 without loss: the new word takes the freed slot.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set state=IDLE, occupancy=0, inflight=0, beat counter=0, buffer contents=0.
REQ-026 SHALL hold fifo_r_en=0, m_valid=0, m_last=0, m_data=0 and busy=0 during reset.
REQ-027 SHALL drop any in-flight word when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, with FIFO_READER_CNT_EN defined, add output word_cnt[15:0] counting pops; it wraps at 65535->0 and clears on reset and flush.
REQ-029 SHALL, without FIFO_READER_CNT_EN, omit the word_cnt port and its logic entirely.

Structure
REQ-030 SHALL place the default DW and BURST_LEN constants and the state enum (IDLE, RUN, FLUSH) in shared package fifo_pkg.
REQ-031 SHALL implement the 2-entry output buffer as sub-module fifo_reader_skid (push, pop, clear, occupancy, head data).

Verification
REQ-032 SHALL verify: 3 words 0xA1,0xA2,0xA3 in FIFO, m_ready=1 -> m_data 0xA1,0xA2,0xA3 on consecutive cycles; first m_valid 2 cycles after first fifo_r_en.
REQ-033 SHALL verify: BURST_LEN=4, 10 words streamed -> m_last=1 on beats 4 and 8 only.
REQ-034 SHALL verify: m_ready=0 for 5 cycles with FIFO non-empty -> fifo_r_en stops after 2 reads; m_data holds; no word lost or duplicated after m_ready=1.
REQ-035 SHALL verify: flush one cycle after fifo_r_en -> returning word dropped; m_valid=0 next cycle; state IDLE after one FLUSH cycle; beat counter restarts at 0.
REQ-036 SHALL verify: rst_n=0 mid-stream with occupancy 2 -> all outputs 0 next cycle; word_cnt=0 when FIFO_READER_CNT_EN is defined.
REQ-037 SHALL verify: fifo_empty=1 throughout -> fifo_r_en never asserted; state stays IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO reader block.
package fifo_pkg;

  localparam int unsigned DefDw       = 32;
  localparam int unsigned DefBurstLen = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer; slot0 is always the head. Empty slots hold zero.
module fifo_reader_skid #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [1:0]    occupancy,
  output logic [DW-1:0] head_data
);

  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop && (occ_q != 2'd0);
  // A full buffer only accepts a word when the head leaves in the same cycle.
  assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (clear) begin
      occ_d   = 2'd0;
      slot0_d = '0;
      slot1_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b01: begin
          slot0_d = slot1_q;
          slot1_d = '0;
          occ_d   = occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) slot0_d = push_data;
          else               slot1_d = push_data;
          occ_d = occ_q + 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            slot0_d = push_data;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign occupancy = occ_q;
  assign head_data = slot0_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO with 1-cycle read latency into a valid/ready stream with burst framing.
// Define FIFO_READER_CNT_EN to add the word_cnt delivered-word counter output.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = DefDw,
  parameter int unsigned BURST_LEN = DefBurstLen
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_r_en,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          flush,
  output logic          busy
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]   word_cnt
`endif
);

  localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);

  state_e     state_q;
  logic       inflight_q;
  logic [7:0] beat_q;
  logic [1:0] occupancy;
  logic       pop, push;

  assign m_valid = (occupancy != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid && (beat_q == LastBeat);
  assign busy    = (state_q != IDLE);

  // Buffered plus returning words must never exceed the two buffer slots.
  always_comb begin
    fifo_r_en = 1'b0;
    if (rst_n && !fifo_empty && !flush && (state_q != FLUSH)) begin
      fifo_r_en = (({1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
    end
  end

  // Data returning during a flush request or the FLUSH cycle is dropped.
  assign push = inflight_q & ~flush & (state_q != FLUSH);

  fifo_reader_skid #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(fifo_rdata),
    .pop      (pop),
    .clear    (flush),
    .occupancy(occupancy),
    .head_data(m_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      beat_q     <= 8'd0;
    end else if (flush) begin
      state_q    <= FLUSH;
      inflight_q <= 1'b0;
      beat_q     <= 8'd0;
    end else begin
      inflight_q <= fifo_r_en;
      if (pop) beat_q <= (beat_q == LastBeat) ? 8'd0 : beat_q + 8'd1;
      unique case (state_q)
        IDLE:    if (!fifo_empty) state_q <= RUN;
        RUN:     if ((occupancy == 2'd0) && !inflight_q && fifo_empty) state_q <= IDLE;
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) word_cnt <= 16'd0;
    else if (pop)        word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FIFO model feeding a scoreboard of expected words.
module tb_fifo_reader;

  localparam int unsigned BL = 4;

  logic        clk = 1'b0;
  logic        rst_n, fifo_empty, flush, m_ready;
  logic [31:0] fifo_rdata, m_data;
  logic        fifo_r_en, m_valid, m_last, busy;
`ifdef FIFO_READER_CNT_EN
  logic [15:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_reader #(
    .DW(32),
    .BURST_LEN(BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .flush     (flush),
    .busy      (busy)
`ifdef FIFO_READER_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int          pop_cyc_q[$];
  int          cyc = 0;
  int          beat = 0;
  int          wcnt = 0;
  int          n_pop = 0;
  int          n_rd = 0;
  int          first_rd = -1;
  int          first_vld = -1;
  logic [31:0] last_mask = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe on the falling edge, then model the FIFO's registered read data after the rise.
  task automatic tick();
    logic        rd;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    rd = fifo_r_en;
    if (rd) begin
      n_rd++;
      check_eq("rd_gate", 32'(fifo_empty), 32'd0);
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (m_valid && m_ready) begin
      n_pop++;
      pop_cyc_q.push_back(cyc);
      if (m_last && n_pop <= 32) last_mask[n_pop-1] = 1'b1;
      if (exp_q.size() == 0) begin
        check_eq("pop_expected", 32'(m_valid & m_ready), 32'd0);
      end else begin
        w = exp_q.pop_front();
        check_eq("data", m_data, w);
        check_eq("last", 32'(m_last), 32'(beat == BL - 1));
        beat = (beat == BL - 1) ? 0 : beat + 1;
        wcnt = (wcnt + 1) % 65536;
      end
    end
    if (flush) begin
      exp_q.delete();
      beat = 0;
      wcnt = 0;
    end
    @(posedge clk);
    #1;
    if (rd && src_q.size() > 0) begin
      fifo_rdata = src_q.pop_front();
      exp_q.push_back(fifo_rdata);
    end else begin
      fifo_rdata = $urandom();
    end
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    m_ready = 1'b1;
    while ((src_q.size() != 0 || exp_q.size() != 0 || m_valid || busy) && k < 100) begin
      tick();
      k++;
    end
    check_eq({tag, "_idle"}, 32'(m_valid | busy), 32'd0);
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
`ifdef FIFO_READER_CNT_EN
    check_eq({tag, "_wcnt"}, 32'(word_cnt), 32'(wcnt));
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_empty = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b0;
    fifo_rdata = '0;
    repeat (3) tick();
    check_eq("rst_r_en", 32'(fifo_r_en), 32'd0);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_last", 32'(m_last), 32'd0);
    check_eq("rst_data", m_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Empty FIFO: no reads, never leaves IDLE.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("empty_r_en", 32'(fifo_r_en), 32'd0);
      check_eq("empty_busy", 32'(busy), 32'd0);
    end

    // Ten words with 4-beat bursts: m_last on beats 4 and 8, full throughput.
    n_pop = 0; last_mask = '0; pop_cyc_q.delete();
    m_ready = 1'b1;
    load(32'hE0, 10);
    drain("burst");
    check_eq("burst_pops", 32'(n_pop), 32'd10);
    check_eq("burst_last_beats", last_mask, 32'h88);
    check_eq("burst_rate", 32'(pop_cyc_q[9] - pop_cyc_q[0]), 32'd9);

    // A1..A3 back to back; first m_valid two cycles after first read.
    n_pop = 0; first_rd = -1; first_vld = -1; pop_cyc_q.delete();
    load(32'hA1, 3);
    drain("seq");
    check_eq("seq_pops", 32'(n_pop), 32'd3);
    check_eq("seq_latency", 32'(first_vld - first_rd), 32'd2);
    check_eq("seq_first_pop", 32'(pop_cyc_q[0]), 32'(first_vld));
    check_eq("seq_consecutive", 32'(pop_cyc_q[2] - pop_cyc_q[0]), 32'd2);

    // Downstream stall: exactly two reads, head word held steady.
    n_pop = 0; n_rd = 0;
    m_ready = 1'b0;
    load(32'hC0, 6);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", 32'(m_valid), 32'd1);
      check_eq("stall_hold", m_data, 32'hC0);
      tick();
    end
    check_eq("stall_reads", 32'(n_rd), 32'd2);
    drain("stall");
    check_eq("stall_pops", 32'(n_pop), 32'd6);

    // Flush one cycle after the first read: returning D0 dropped, burst count restarts.
    m_ready = 1'b1;
    load(32'hD0, 6);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_valid", 32'(m_valid), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd1);
    check_eq("flush_r_en", 32'(fifo_r_en), 32'd0);
    tick();
    check_eq("flush_idle", 32'(busy), 32'd0);
    n_pop = 0; last_mask = '0;
    drain("flush");
    check_eq("flush_pops", 32'(n_pop), 32'd5);
    check_eq("flush_last_beats", last_mask, 32'h08);

    // Reset mid-stream with both buffer slots full.
    m_ready = 1'b0;
    load(32'hF0, 4);
    repeat (4) tick();
    check_eq("pre_rst_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_r_en", 32'(fifo_r_en), 32'd0);
    check_eq("mid_rst_valid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_last", 32'(m_last), 32'd0);
    check_eq("mid_rst_data", m_data, 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_READER_CNT_EN
    check_eq("mid_rst_wcnt", 32'(word_cnt), 32'd0);
`endif
    src_q.delete();
    exp_q.delete();
    beat = 0;
    wcnt = 0;
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_valid", 32'(m_valid), 32'd0);

    n_pop = 0;
    load(32'h60, 2);
    drain("post_rst");
    check_eq("post_rst_pops", 32'(n_pop), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
